// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache: FSM state
// encoding, the NOP returned when nothing is fetched, and address field widths.
package icache_pkg;

  // state     | meaning
  // S_IDLE    | serving hits; a miss with READ high starts a refill
  // S_MEM_READ| block request held on the memory port until data is ready
  // S_UPDATE  | latched block written into the line at the exit edge
  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MEM_READ = 2'd1,
    S_UPDATE   = 2'd2
  } icache_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int ADDR_W      = 32;
  localparam int WORD_W      = 32;
  localparam int BLOCK_W     = 128;
  localparam int WORD_OFF_W  = 2;
  localparam int BLOCK_OFF_W = 4;
  localparam int MEM_ADDR_W  = ADDR_W - BLOCK_OFF_W;

  // Pick one 32-bit word out of a 128-bit block; word 0 sits in bits [31:0].
  function automatic logic [WORD_W-1:0] select_word(input logic [BLOCK_W-1:0] blk,
                                                    input logic [WORD_OFF_W-1:0] off);
    logic [WORD_W-1:0] w;
    case (off)
      2'd0:    w = blk[31:0];
      2'd1:    w = blk[63:32];
      2'd2:    w = blk[95:64];
      default: w = blk[127:96];
    endcase
    return w;
  endfunction

endpackage

// File: rtl/icache_store.sv
// Line storage for the instruction cache: valid bits, tags and 128-bit blocks.
// Reads are asynchronous so a hit resolves in the same cycle; writes are
// synchronous. Valid bits clear asynchronously on reset; tags/data do not
// need a reset because they are only trusted behind a valid bit.
module icache_store
  import icache_pkg::*;
#(
  parameter int NUM_BLOCKS = 8,
  parameter int IDX_W      = $clog2(NUM_BLOCKS),
  parameter int TAG_W      = ADDR_W - BLOCK_OFF_W - IDX_W
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [IDX_W-1:0]   i_rd_idx,
  output logic               o_rd_valid,
  output logic [TAG_W-1:0]   o_rd_tag,
  output logic [BLOCK_W-1:0] o_rd_data,
  input  logic               i_wr_en,
  input  logic [IDX_W-1:0]   i_wr_idx,
  input  logic [TAG_W-1:0]   i_wr_tag,
  input  logic [BLOCK_W-1:0] i_wr_data
);

  logic [NUM_BLOCKS-1:0] r_valid;
  logic [TAG_W-1:0]      r_tag  [NUM_BLOCKS];
  logic [BLOCK_W-1:0]    r_data [NUM_BLOCKS];

  // Valid bits: cleared on reset, set when a refilled line is written.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      r_valid[i_wr_idx] <= 1'b1;
    end
  end

  // Tag and block contents: plain write port, no reset.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_tag[i_wr_idx]  <= i_wr_tag;
      r_data[i_wr_idx] <= i_wr_data;
    end
  end

  assign o_rd_valid = r_valid[i_rd_idx];
  assign o_rd_tag   = r_tag[i_rd_idx];
  assign o_rd_data  = r_data[i_rd_idx];

endmodule

// File: rtl/instruction_cache.sv
// Read-only direct-mapped instruction cache with zero-cycle hits and a
// three-state refill FSM (see icache_pkg for the state table).
// Optional build macro: ICACHE_STATS_EN adds saturating HIT_COUNT/MISS_COUNT.
module instruction_cache
  import icache_pkg::*;
#(
  parameter int NUM_BLOCKS = 8
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  READ,
  input  logic [ADDR_W-1:0]     ADDRESS,
  output logic [WORD_W-1:0]     INSTRUCTION,
  output logic                  BUSYWAIT,
  output logic                  MEM_READ,
  output logic [MEM_ADDR_W-1:0] MEM_ADDRESS,
  input  logic [BLOCK_W-1:0]    MEM_READDATA,
  input  logic                  MEM_BUSYWAIT
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]           HIT_COUNT,
  output logic [31:0]           MISS_COUNT
`endif
);

  localparam int IDX_W = $clog2(NUM_BLOCKS);
  localparam int TAG_W = ADDR_W - BLOCK_OFF_W - IDX_W;

  icache_state_t        r_state;
  logic                 r_mem_read;
  logic [BLOCK_W-1:0]   r_fill_data;

  logic [WORD_OFF_W-1:0] w_offset;
  logic [IDX_W-1:0]      w_index;
  logic [TAG_W-1:0]      w_tag;
  logic                  w_line_valid;
  logic [TAG_W-1:0]      w_line_tag;
  logic [BLOCK_W-1:0]    w_line_data;
  logic                  w_hit;
  logic                  w_wr_en;
  logic                  w_start_miss;
  logic [1:0]            w_unused_addr_lsb;

  // Byte offset within a word is irrelevant for a word-aligned fetch.
  assign w_unused_addr_lsb = ADDRESS[1:0];

  assign w_offset = ADDRESS[BLOCK_OFF_W-1:2];
  assign w_index  = ADDRESS[BLOCK_OFF_W +: IDX_W];
  assign w_tag    = ADDRESS[ADDR_W-1 -: TAG_W];

  icache_store #(
    .NUM_BLOCKS (NUM_BLOCKS),
    .IDX_W      (IDX_W),
    .TAG_W      (TAG_W)
  ) u_store (
    .i_clk      (CLK),
    .i_rst_n    (RESET),
    .i_rd_idx   (w_index),
    .o_rd_valid (w_line_valid),
    .o_rd_tag   (w_line_tag),
    .o_rd_data  (w_line_data),
    .i_wr_en    (w_wr_en),
    .i_wr_idx   (w_index),
    .i_wr_tag   (w_tag),
    .i_wr_data  (r_fill_data)
  );

  assign w_hit        = READ & w_line_valid & (w_line_tag == w_tag);
  assign w_start_miss = (r_state == S_IDLE) & READ & ~w_hit;
  // ADDRESS is held by the fetch stage for the whole miss, so the write
  // can take index/tag straight from it.
  assign w_wr_en      = (r_state == S_UPDATE);

  // Refill FSM; MEM_READ is registered so it is high exactly in S_MEM_READ.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state     <= S_IDLE;
      r_mem_read  <= 1'b0;
      r_fill_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start_miss) begin
            r_state    <= S_MEM_READ;
            r_mem_read <= 1'b1;
          end
        end
        S_MEM_READ: begin
          // Memory status is only looked at from inside this state, which
          // guarantees at least one request cycle even with a ready memory.
          if (!MEM_BUSYWAIT) begin
            r_state     <= S_UPDATE;
            r_mem_read  <= 1'b0;
            r_fill_data <= MEM_READDATA;
          end
        end
        S_UPDATE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state    <= S_IDLE;
          r_mem_read <= 1'b0;
        end
      endcase
    end
  end

  // Fetch-side outputs: hit word and stall resolve in the same cycle.
  always_comb begin
    INSTRUCTION = NOP_INSTR;
    BUSYWAIT    = 1'b1;
    if (r_state == S_IDLE) begin
      BUSYWAIT = READ & ~w_hit;
      if (w_hit) begin
        INSTRUCTION = select_word(w_line_data, w_offset);
      end
    end
  end

  assign MEM_READ    = r_mem_read;
  assign MEM_ADDRESS = ADDRESS[ADDR_W-1:BLOCK_OFF_W];

`ifdef ICACHE_STATS_EN
  logic [31:0] r_hit_count;
  logic [31:0] r_miss_count;

  // Saturating event counters: one miss per refill start, one hit per IDLE hit cycle.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      if ((r_state == S_IDLE) && w_hit && (r_hit_count != 32'hFFFF_FFFF)) begin
        r_hit_count <= r_hit_count + 32'd1;
      end
      if (w_start_miss && (r_miss_count != 32'hFFFF_FFFF)) begin
        r_miss_count <= r_miss_count + 32'd1;
      end
    end
  end

  assign HIT_COUNT  = r_hit_count;
  assign MISS_COUNT = r_miss_count;
`endif

endmodule

// File: tb/tb_instruction_cache.sv
// Directed bench for instruction_cache (NUM_BLOCKS = 8). A small memory
// model answers block reads after a programmable number of busy cycles.
module tb_instruction_cache;

  logic         CLK = 1'b0;
  logic         RESET = 1'b0;
  logic         READ = 1'b0;
  logic [31:0]  ADDRESS = 32'h0;
  logic [31:0]  INSTRUCTION;
  logic         BUSYWAIT;
  logic         MEM_READ;
  logic [27:0]  MEM_ADDRESS;
  logic [127:0] MEM_READDATA = '0;
  logic         MEM_BUSYWAIT = 1'b0;
`ifdef ICACHE_STATS_EN
  logic [31:0]  HIT_COUNT;
  logic [31:0]  MISS_COUNT;
`endif

  int total = 0;
  int bad = 0;
  int mem_busy_n = 5;
  int mem_cnt = 0;

  instruction_cache #(.NUM_BLOCKS(8)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .READ         (READ),
    .ADDRESS      (ADDRESS),
    .INSTRUCTION  (INSTRUCTION),
    .BUSYWAIT     (BUSYWAIT),
    .MEM_READ     (MEM_READ),
    .MEM_ADDRESS  (MEM_ADDRESS),
    .MEM_READDATA (MEM_READDATA),
    .MEM_BUSYWAIT (MEM_BUSYWAIT)
`ifdef ICACHE_STATS_EN
    ,
    .HIT_COUNT    (HIT_COUNT),
    .MISS_COUNT   (MISS_COUNT)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Block 0 holds the reference program; other blocks hold {block_addr, word}.
  function automatic logic [127:0] mem_block(input logic [27:0] b);
    if (b == 28'h0) return 128'h0000_0293_0000_0113_0000_00B3_0000_0013;
    return {b, 4'h3, b, 4'h2, b, 4'h1, b, 4'h0};
  endfunction

  // Memory model: busy for mem_busy_n request cycles, then data with busy low.
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (MEM_READ) begin
        if (mem_cnt < mem_busy_n) begin
          MEM_BUSYWAIT = 1'b1;
          mem_cnt++;
        end else begin
          MEM_BUSYWAIT = 1'b0;
          MEM_READDATA = mem_block(MEM_ADDRESS);
        end
      end else begin
        mem_cnt = 0;
        MEM_BUSYWAIT = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  // Count edges until the stall clears; a runaway shows up as a wrong count.
  task automatic wait_fill(input string tag, input int exp_edges);
    int n = 0;
    while (BUSYWAIT === 1'b1 && n < 60) begin
      tick();
      n++;
    end
    check_val(tag, 32'(n), 32'(exp_edges));
  endtask

  initial begin
    // Reset state, READ low then high
    #12;
    check_val("rst_busy_noread", {31'h0, BUSYWAIT}, 32'h0);
    check_val("rst_memread", {31'h0, MEM_READ}, 32'h0);
    check_val("rst_nop", INSTRUCTION, 32'h0000_0013);
    READ = 1'b1;
    #1;
    check_val("rst_busy_read", {31'h0, BUSYWAIT}, 32'h1);
    tick();
    check_val("rst_memread_hold", {31'h0, MEM_READ}, 32'h0);
`ifdef ICACHE_STATS_EN
    check_val("rst_hits", HIT_COUNT, 32'h0);
    check_val("rst_misses", MISS_COUNT, 32'h0);
`endif

    // Cold miss at 0x0: request edge, then 7 stall cycles (5 busy + 2)
    RESET = 1'b1;
    ADDRESS = 32'h0000_0000;
    #1;
    check_val("miss0_busy", {31'h0, BUSYWAIT}, 32'h1);
    tick();
    check_val("miss0_memread", {31'h0, MEM_READ}, 32'h1);
    check_val("miss0_memaddr", {4'h0, MEM_ADDRESS}, 32'h0);
    check_val("miss0_busy2", {31'h0, BUSYWAIT}, 32'h1);
    wait_fill("miss0_penalty", 7);
    check_val("miss0_instr", INSTRUCTION, 32'h0000_0013);
    check_val("miss0_memread_off", {31'h0, MEM_READ}, 32'h0);

    // Next cycle: hit on word 2 without memory traffic
    tick();
    ADDRESS = 32'h0000_0008;
    #1;
    check_val("hit8_busy", {31'h0, BUSYWAIT}, 32'h0);
    check_val("hit8_instr", INSTRUCTION, 32'h0000_0113);
    tick();
    check_val("hit8_nomem", {31'h0, MEM_READ}, 32'h0);
    READ = 1'b0;
    #1;
    check_val("noread_busy", {31'h0, BUSYWAIT}, 32'h0);
    check_val("noread_nop", INSTRUCTION, 32'h0000_0013);
`ifdef ICACHE_STATS_EN
    check_val("stats_hits", HIT_COUNT, 32'd2);
    check_val("stats_misses", MISS_COUNT, 32'd1);
`endif

    // Remaining words; low address bits ignored
    READ = 1'b1;
    ADDRESS = 32'h0000_0004;
    #1;
    check_val("hit4_instr", INSTRUCTION, 32'h0000_00B3);
    ADDRESS = 32'h0000_000E;
    #1;
    check_val("hitE_instr", INSTRUCTION, 32'h0000_0293);

    // Conflict: 0x80 maps to index 0 with a new tag, then 0x0 misses again
    ADDRESS = 32'h0000_0080;
    #1;
    check_val("miss80_busy", {31'h0, BUSYWAIT}, 32'h1);
    tick();
    check_val("miss80_memaddr", {4'h0, MEM_ADDRESS}, 32'h0000_0008);
    wait_fill("miss80_penalty", 7);
    check_val("miss80_instr", INSTRUCTION, 32'h0000_0080);
    ADDRESS = 32'h0000_0084;
    #1;
    check_val("hit84_instr", INSTRUCTION, 32'h0000_0081);
    ADDRESS = 32'h0000_0000;
    #1;
    check_val("evict0_busy", {31'h0, BUSYWAIT}, 32'h1);
    tick();
    wait_fill("evict0_penalty", 7);
    check_val("evict0_instr", INSTRUCTION, 32'h0000_0013);

    // Ready memory: still one MEM_READ cycle, penalty 0 + 2
    mem_busy_n = 0;
    tick();
    ADDRESS = 32'h0000_0010;
    #1;
    check_val("fast_busy", {31'h0, BUSYWAIT}, 32'h1);
    tick();
    check_val("fast_memread", {31'h0, MEM_READ}, 32'h1);
    wait_fill("fast_penalty", 2);
    check_val("fast_instr", INSTRUCTION, 32'h0000_0010);
    ADDRESS = 32'h0000_0018;
    #1;
    check_val("hit18_instr", INSTRUCTION, 32'h0000_0012);
    mem_busy_n = 5;

    // Reset in the middle of a refill aborts it and drops all lines
    tick();
    ADDRESS = 32'h0000_0020;
    tick();
    tick();
    tick();
    check_val("abort_pre_memread", {31'h0, MEM_READ}, 32'h1);
    RESET = 1'b0;
    #1;
    check_val("abort_memread", {31'h0, MEM_READ}, 32'h0);
    check_val("abort_busy", {31'h0, BUSYWAIT}, 32'h1);
    tick();
    RESET = 1'b1;
    ADDRESS = 32'h0000_0000;
    #1;
    check_val("post_rst_miss0", {31'h0, BUSYWAIT}, 32'h1);
    ADDRESS = 32'h0000_0010;
    #1;
    check_val("post_rst_miss10", {31'h0, BUSYWAIT}, 32'h1);
    ADDRESS = 32'h0000_0020;
    #1;
    check_val("post_rst_miss20", {31'h0, BUSYWAIT}, 32'h1);
    READ = 1'b0;
    #1;
    check_val("post_rst_idle", {31'h0, BUSYWAIT}, 32'h0);
    tick();
    check_val("post_rst_nomem", {31'h0, MEM_READ}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
